rr_mux_arb: RTL

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a valid/ready handshake on every channel and one registered output stage. It succeeds the fixed 4:1 16-bit combinational mux by adding input arbitration, packet locking and backpressure. It sits between several producer streams and a single consumer, such as a shared bus or register-file write port. The arbitration policy is chosen at compile time.

---
 rtl/rr_mux_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rr_mux_arb.sv
// N-channel arbitrated mux with valid/ready handshakes, packet locking and a registered output stage.
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise the lowest-index valid channel wins.
module rr_mux_arb #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  lock_ch_q, lock_ch_d;

    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;
    logic             out_last_q;
    logic             out_valid_q;

    logic             load;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_last;
    logic             xfer;

`ifdef MUX_ARB_RR_EN
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic [SELW-1:0]  ptr_q, ptr_d;

    // Increment with explicit wrap so indices >= N never appear when N is not a power of 2.
    function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] c);
        return (c == LAST_CH) ? '0 : c + SELW'(1);
    endfunction
`endif

    assign load = !out_valid_q || out_ready;
    assign xfer = gnt_vld && load;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state_q == LOCKED) begin
            gnt_vld = in_valid[lock_ch_q];
            gnt_idx = lock_ch_q;
        end else begin
`ifdef MUX_ARB_RR_EN
            logic [SELW-1:0] cand;
            cand = ptr_q;
            for (int k = 0; k < N; k++) begin
                if (!gnt_vld && in_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
                cand = next_ch(cand);
            end
`else
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[k]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
`endif
        end
    end

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt_data = in_data[k*WIDTH +: WIDTH];
                gnt_last = in_last[k];
            end
        end
    end

    // Gated with rst_n so no handshake can complete while reset is held.
    always_comb begin
        in_ready = '0;
        if (xfer && rst_n) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            if (gnt_last) begin
                state_d = IDLE;
            end else begin
                state_d   = LOCKED;
                lock_ch_d = gnt_idx;
            end
        end
    end

`ifdef MUX_ARB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer && gnt_last) begin
            ptr_d = next_ch(gnt_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= gnt_vld;
            if (gnt_vld) begin
                out_data_q <= gnt_data;
                out_sel_q  <= gnt_idx;
                out_last_q <= gnt_last;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule
